mult8_ctrl: RTL and testbench
=============================

Name: mult8_ctrl

Overview:
Sequential 8x8 signed (two's-complement) shift-add multiplier datapath plus control FSM. It is the direct consumer of add_sub9: it drives add_sub9's A/B/fn inputs and registers the 9-bit S result into the X:A accumulator. The product is held in A:B (16 bits), and X holds the sign extension. The block sits between the debounced, synchronized board inputs and the hex-display/LED drivers.

Parameters:
none; operand width fixed at 8 by add_sub9. The iteration count is taken from the package constant MULT_ITERS = 8.

Ports:
Clk  in  1  system clock, all state changes on rising edge
Reset_n  in  1  asynchronous active-low reset
ClearA_LoadB  in  1  level, already synchronized; honoured only in IDLE
Run  in  1  level, already synchronized; start request
Switches  in  8  multiplicand S / multiplier load value
Aval  out  8  register A (product high byte)
Bval  out  8  register B (product low byte / multiplier)
Xval  out  1  sign-extension bit X
Busy  out  1  high in ADD and SHIFT states
Done  out  1  high in DONE state

Behaviour:
- Reset (Reset_n low, async): state=IDLE; A=0, B=0, X=0, S_reg=0, count=0; Busy=0, Done=0. Reset mid-operation aborts immediately with the same values.
- IDLE:
  - If ClearA_LoadB=1 and Run=0: A<=0, X<=0, B<=Switches next edge.
  - If Run=1: S_reg<=Switches, A<=0, X<=0, count<=0, go to ADD. B is untouched.
  - If both are high, Run wins and B is not reloaded.
- ADD (1 cycle):
  - add_sub9 inputs: A, S_reg, fn = (count == MULT_ITERS-1).
  - If B[0]=1: {X,A} <= S[8:0] from add_sub9.
  - If B[0]=0: X <= A[7], A unchanged.
  - Go to SHIFT.
- SHIFT (1 cycle): arithmetic right shift of the 17-bit {X,A,B}. X keeps its value; A[7]<=X; B[7]<=A[0]; B[0] is discarded. count<=count+1. If count was MULT_ITERS-1, go to DONE; else go to ADD.
- DONE: Done=1. Stay while Run=1; when Run=0, go to IDLE. A re-press of Run therefore requires a release first, and each press produces exactly one multiply.
- Latency: Run sampled high in IDLE -> Done asserted exactly 17 edges later (1 start + 8 × (ADD+SHIFT)).
- Result: {A,B} = signed 16-bit product of S_reg and the original B. Xval equals A[7] in DONE.
- Outputs are direct register values. They change only on clock edges, or asynchronously on reset.
- Inputs are ignored while Busy=1. Switches may change during Busy with no effect, because S_reg is latched.
- Consecutive Run without ClearA_LoadB: the multiplier is the previous product's low byte. This is defined, intended behaviour.
- count is 4 bits. count==8 is never held outside the SHIFT→DONE transition.

Decomposition:
- Package mult8_pkg:
  - state enum typedef: IDLE, ADD, SHIFT, DONE
  - MULT_ITERS = 8
  - COUNT_W = 4
- Sub-modules:
  - Instantiate the existing add_sub9 unchanged for the add/subtract.
  - One natural new sub-module, mult8_fsm: state register, count, next-state and control strobes (clr_ld, ld_s, add_en, shift_en, fn). The datapath registers remain in mult8_ctrl.

Test Plan:
- Reset/clear/load: assert Reset_n low during Busy (count=3) -> A=0, B=0, X=0, Busy=0 asynchronously; then ClearA_LoadB with Switches=0x3B -> B=0x3B, A=0, X=0.
- Positive × positive: load B=0x3B (59), Switches=0x07, pulse Run -> after 17 edges Done=1, A=0x01, B=0x9D, X=0.
- Mixed signs:
  - B=0xC5 (-59), S=0x07 -> A=0xFE, B=0x63, X=1.
  - B=0x3B, S=0xF9 (-7) -> A=0xFE, B=0x63, X=1.
- Negative × negative and extreme: B=0xC5, S=0xF9 -> A=0x01, B=0x9D, X=0. B=0x80, S=0x80 -> A=0x40, B=0x00, X=0 (exercises the final-iteration subtract).
- Run handling: hold Run high for 40 cycles -> exactly one multiply, Done stays 1. Release Run -> IDLE. Re-press without reload (S=0x02, B=0x9D from the previous product) -> product 0xFF3A.
- Input isolation: toggle Switches and ClearA_LoadB every cycle while Busy -> result identical to the clean run; B is not reloaded.

Source files
------------

// File: rtl/mult8_pkg.sv
// Shared types and constants for the 8x8 signed shift-add multiplier.
package mult8_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ADD,
        SHIFT,
        DONE
    } state_t;

    localparam int unsigned MULT_ITERS = 8;
    localparam int unsigned COUNT_W    = 4;

    localparam logic [COUNT_W-1:0] LAST_ITER = COUNT_W'(MULT_ITERS - 1);

endpackage

// File: rtl/add_sub9.sv
// 9-bit signed adder/subtractor: S = sext(A) + sext(B) when fn=0, sext(A) - sext(B) when fn=1.
module add_sub9 (
    input  logic [7:0] A,
    input  logic [7:0] B,
    input  logic       fn,
    output logic [8:0] S
);

    logic [8:0] a_ext;
    logic [8:0] b_ext;

    always_comb begin
        a_ext = {A[7], A};
        b_ext = {B[7], B} ^ {9{fn}};
        // Two's-complement subtract: invert and add fn as the carry-in.
        S     = a_ext + b_ext + {8'b0, fn};
    end

endmodule

// File: rtl/mult8_fsm.sv
// Control sequencer for mult8_ctrl: state, iteration count and datapath strobes.
module mult8_fsm
    import mult8_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic run,
    input  logic clear_a_load_b,
    output logic clr_ld,
    output logic ld_s,
    output logic add_en,
    output logic shift_en,
    output logic fn,
    output logic busy,
    output logic done
);

    state_t             state;
    state_t             state_next;
    logic [COUNT_W-1:0] count;
    logic               last_iter;

    assign last_iter = (count == LAST_ITER);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            count <= '0;
        end else begin
            state <= state_next;
            if (ld_s) begin
                count <= '0;
            end else if (shift_en) begin
                // Wrap on the final shift so the terminal count is never held in DONE.
                count <= last_iter ? '0 : count + 1'b1;
            end
        end
    end

    always_comb begin
        state_next = state;
        clr_ld     = 1'b0;
        ld_s       = 1'b0;
        add_en     = 1'b0;
        shift_en   = 1'b0;
        fn         = 1'b0;
        busy       = 1'b0;
        done       = 1'b0;

        unique case (state)
            IDLE: begin
                if (run) begin
                    ld_s       = 1'b1;
                    state_next = ADD;
                end else if (clear_a_load_b) begin
                    clr_ld = 1'b1;
                end
            end
            ADD: begin
                busy       = 1'b1;
                add_en     = 1'b1;
                fn         = last_iter;
                state_next = SHIFT;
            end
            SHIFT: begin
                busy       = 1'b1;
                shift_en   = 1'b1;
                state_next = last_iter ? DONE : ADD;
            end
            DONE: begin
                done = 1'b1;
                if (!run) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

endmodule

// File: rtl/mult8_ctrl.sv
// Sequential 8x8 signed shift-add multiplier: X:A:B datapath around add_sub9, sequenced by mult8_fsm.
module mult8_ctrl
    import mult8_pkg::*;
(
    input  logic       Clk,
    input  logic       Reset_n,
    input  logic       ClearA_LoadB,
    input  logic       Run,
    input  logic [7:0] Switches,
    output logic [7:0] Aval,
    output logic [7:0] Bval,
    output logic       Xval,
    output logic       Busy,
    output logic       Done
);

    logic       clr_ld;
    logic       ld_s;
    logic       add_en;
    logic       shift_en;
    logic       fn;
    logic [7:0] a_reg;
    logic [7:0] b_reg;
    logic [7:0] s_reg;
    logic       x_reg;
    logic [8:0] sum;

    mult8_fsm u_fsm (
        .clk            (Clk),
        .rst_n          (Reset_n),
        .run            (Run),
        .clear_a_load_b (ClearA_LoadB),
        .clr_ld         (clr_ld),
        .ld_s           (ld_s),
        .add_en         (add_en),
        .shift_en       (shift_en),
        .fn             (fn),
        .busy           (Busy),
        .done           (Done)
    );

    add_sub9 u_add_sub9 (
        .A  (a_reg),
        .B  (s_reg),
        .fn (fn),
        .S  (sum)
    );

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            a_reg <= '0;
            b_reg <= '0;
            s_reg <= '0;
            x_reg <= 1'b0;
        end else if (ld_s) begin
            s_reg <= Switches;
            a_reg <= '0;
            x_reg <= 1'b0;
        end else if (clr_ld) begin
            a_reg <= '0;
            x_reg <= 1'b0;
            b_reg <= Switches;
        end else if (add_en) begin
            if (b_reg[0]) begin
                {x_reg, a_reg} <= sum;
            end else begin
                x_reg <= a_reg[7];
            end
        end else if (shift_en) begin
            a_reg <= {x_reg, a_reg[7:1]};
            b_reg <= {a_reg[0], b_reg[7:1]};
        end
    end

    assign Aval = a_reg;
    assign Bval = b_reg;
    assign Xval = x_reg;

endmodule

// File: tb/tb_mult8_ctrl.sv
// Scoreboard bench for mult8_ctrl: expected products are queued at Run and compared when Done rises.
module tb_mult8_ctrl;

    logic       Clk;
    logic       Reset_n;
    logic       ClearA_LoadB;
    logic       Run;
    logic [7:0] Switches;
    logic [7:0] Aval;
    logic [7:0] Bval;
    logic       Xval;
    logic       Busy;
    logic       Done;

    int unsigned n_vec;
    int unsigned n_bad;
    logic [16:0] exp_q[$];
    logic [7:0]  mdl_b;

    mult8_ctrl dut (
        .Clk          (Clk),
        .Reset_n      (Reset_n),
        .ClearA_LoadB (ClearA_LoadB),
        .Run          (Run),
        .Switches     (Switches),
        .Aval         (Aval),
        .Bval         (Bval),
        .Xval         (Xval),
        .Busy         (Busy),
        .Done         (Done)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic load_b(input logic [7:0] b);
        ClearA_LoadB = 1'b1;
        Switches     = b;
        step();
        ClearA_LoadB = 1'b0;
        mdl_b        = b;
        check("load_b", {24'b0, Bval}, {24'b0, b});
        check("load_a", {24'b0, Aval}, 32'h0);
        check("load_x", {31'b0, Xval}, 32'h0);
    endtask

    task automatic run_mult(input logic [7:0] s, input int unsigned hold, input bit noisy);
        logic [15:0] prod;
        logic [16:0] exp;
        int unsigned edges;
        bit          got;
        prod = 16'($signed(s) * $signed(mdl_b));
        exp_q.push_back({prod[15], prod});
        Switches = s;
        Run      = 1'b1;
        if (noisy) ClearA_LoadB = 1'b1;
        got   = 1'b0;
        edges = 0;
        while (!got && edges < 40) begin
            step();
            edges++;
            if (hold == 0) Run = 1'b0;
            if (noisy) begin
                Switches     = 8'($urandom);
                ClearA_LoadB = ~ClearA_LoadB;
            end
            if (Done) got = 1'b1;
        end
        ClearA_LoadB = 1'b0;
        check("latency", edges, got ? 32'd17 : 32'd0);
        exp = exp_q.pop_front();
        check("prod_x", {31'b0, Xval}, {31'b0, exp[16]});
        check("prod_a", {24'b0, Aval}, {24'b0, exp[15:8]});
        check("prod_b", {24'b0, Bval}, {24'b0, exp[7:0]});
        check("busy_done", {31'b0, Busy}, 32'h0);
        if (hold > 0) begin
            repeat (hold) step();
            check("hold_done", {31'b0, Done}, 32'h1);
            check("hold_prod", {16'b0, Aval, Bval}, {16'b0, exp[15:0]});
            Run = 1'b0;
        end
        step();
        check("idle_done", {31'b0, Done}, 32'h0);
        check("idle_prod", {15'b0, Xval, Aval, Bval}, {15'b0, exp});
        mdl_b = exp[7:0];
    endtask

    initial begin
        n_vec        = 0;
        n_bad        = 0;
        Reset_n      = 1'b0;
        ClearA_LoadB = 1'b0;
        Run          = 1'b0;
        Switches     = 8'h00;
        mdl_b        = 8'h00;
        #12;
        check("rst_state", {20'b0, Xval, Aval, Bval, Busy, Done}, 32'h0);
        @(negedge Clk);
        Reset_n = 1'b1;
        step();

        // Abort a multiply partway through with an asynchronous reset.
        load_b(8'h3B);
        Switches = 8'h07;
        Run      = 1'b1;
        step();
        Run = 1'b0;
        repeat (6) step();
        check("mid_busy", {31'b0, Busy}, 32'h1);
        #2;
        Reset_n = 1'b0;
        #1;
        check("async_rst", {20'b0, Xval, Aval, Bval, Busy, Done}, 32'h0);
        @(negedge Clk);
        Reset_n = 1'b1;
        mdl_b   = 8'h00;
        step();

        load_b(8'h3B);
        run_mult(8'h07, 0, 1'b0);
        load_b(8'hC5);
        run_mult(8'h07, 0, 1'b0);
        load_b(8'h3B);
        run_mult(8'hF9, 0, 1'b0);
        load_b(8'hC5);
        run_mult(8'hF9, 40, 1'b0);
        run_mult(8'h02, 0, 1'b0);
        load_b(8'h80);
        run_mult(8'h80, 0, 1'b0);
        load_b(8'h7F);
        run_mult(8'h80, 0, 1'b0);
        load_b(8'h3B);
        run_mult(8'h07, 0, 1'b1);
        for (int i = 0; i < 6; i++) begin
            load_b(8'($urandom));
            run_mult(8'($urandom), 0, (i % 2) == 1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
